// File: rtl/branch_history_table.sv
// Two-bit saturating-counter branch history table with a power-up init sweep.
// Optional statistics counters are enabled by defining BHT_STATS_EN.
//
// state   | meaning
// S_INIT  | sweeping INIT_STATE into every entry; lookups and updates are ignored
// S_READY | table usable; lookups return a prediction, conditional updates train it
module branch_history_table #(
    parameter int          INDEX_BITS = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic                  Ready,
    input  logic                  LookupValid,
    input  logic [31:0]           LookupPC,
    output logic                  PredValid,
    output logic                  PredTaken,
    output logic [INDEX_BITS-1:0] PredIndex,
    input  logic                  UpdateValid,
    input  logic [INDEX_BITS-1:0] UpdateIndex,
    input  logic [3:0]            UpdateBranchType,
    input  logic                  UpdateBranch,
    input  logic                  UpdatePredTaken,
`ifdef BHT_STATS_EN
    output logic [31:0]           UpdateCount,
    output logic [31:0]           MispredictCount,
`endif
    output logic                  Mispredict
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] PTR_ONE  = 1;
    localparam logic [INDEX_BITS-1:0] PTR_LAST = DEPTH - 1;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t                  state_q;
    logic [INDEX_BITS-1:0]   ptr_q;
    logic                    pred_valid_q;
    logic                    pred_taken_q;
    logic [INDEX_BITS-1:0]   pred_index_q;
    logic                    mispredict_q;
    logic [1:0]              bht_q [DEPTH];

    logic [INDEX_BITS-1:0]   lookup_idx;
    logic                    is_cond;
    logic                    upd_en;
    logic                    sweep_we;
    logic [1:0]              cnt_cur;
    logic [1:0]              cnt_d;
    logic                    lookup_taken;
    logic                    misp_d;
    logic                    unused_pc;

    assign lookup_idx = LookupPC[INDEX_BITS+1:2];
    assign unused_pc  = ^{LookupPC[31:INDEX_BITS+2], LookupPC[1:0]};

    // bgez, beq, bne, bgtz, blez, bltz train the table; jumps and anything else do not
    always_comb begin
        is_cond = 1'b0;
        case (UpdateBranchType)
            4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000: is_cond = 1'b1;
            default:                   is_cond = 1'b0;
        endcase
    end

    assign upd_en   = !Reset && (state_q == S_READY) && UpdateValid && is_cond;
    assign sweep_we = !Reset && (state_q == S_INIT);
    assign cnt_cur  = bht_q[UpdateIndex];
    assign misp_d   = upd_en && (UpdateBranch != UpdatePredTaken);

    always_comb begin
        cnt_d = cnt_cur;
        if (UpdateBranch) begin
            if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is visible to the lookup
    always_comb begin
        lookup_taken = bht_q[lookup_idx][1];
        if (upd_en && (UpdateIndex == lookup_idx)) lookup_taken = cnt_d[1];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_INIT;
            ptr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
            mispredict_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    pred_valid_q <= 1'b0;
                    mispredict_q <= 1'b0;
                    ptr_q        <= ptr_q + PTR_ONE;
                    if (ptr_q == PTR_LAST) state_q <= S_READY;
                end
                S_READY: begin
                    pred_valid_q <= LookupValid;
                    if (LookupValid) begin
                        pred_index_q <= lookup_idx;
                        pred_taken_q <= lookup_taken;
                    end
                    mispredict_q <= misp_d;
                end
                default: begin
                    state_q <= S_INIT;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Table contents are not reset; the init sweep establishes them
    always_ff @(posedge Clk) begin
        if (sweep_we) begin
            bht_q[ptr_q] <= INIT_STATE;
        end else if (upd_en) begin
            bht_q[UpdateIndex] <= cnt_d;
        end
    end

    assign Ready      = (state_q == S_READY);
    assign PredValid  = pred_valid_q;
    assign PredTaken  = pred_taken_q;
    assign PredIndex  = pred_index_q;
    assign Mispredict = mispredict_q;

`ifdef BHT_STATS_EN
    logic [31:0] upd_count_q;
    logic [31:0] misp_count_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            upd_count_q  <= '0;
            misp_count_q <= '0;
        end else begin
            if (upd_en) upd_count_q  <= upd_count_q + 32'd1;
            if (misp_d) misp_count_q <= misp_count_q + 32'd1;
        end
    end

    assign UpdateCount     = upd_count_q;
    assign MispredictCount = misp_count_q;
`endif

endmodule
